// File: rtl/adaptive_tpm_engine.sv
// Adaptive IMM transition-probability engine: classifies mode probabilities, tracks model
// activity with hysteresis and streams one TPM row per handshake (row 0 two cycles after accept).
module adaptive_tpm_engine #(
  parameter int N_MODELS  = 3,
  parameter int W         = 32,
  parameter int DEACT_CNT = 8,
  parameter int REACT_CNT = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_MODELS*W-1:0]      mu,
  input  logic [N_MODELS*W-1:0]      nis,
  input  logic                       maneuver,
  input  logic                       vs_enable,
  input  logic [W-1:0]               cfg_p_base,
  input  logic [W-1:0]               cfg_p_high,
  input  logic [W-1:0]               cfg_p_med,
  input  logic [W-1:0]               cfg_p_low,
  input  logic [W-1:0]               cfg_conf_hi,
  input  logic [W-1:0]               cfg_conf_med,
  input  logic [W-1:0]               cfg_nis_thr,
  input  logic [W-1:0]               cfg_mu_off,
  input  logic [W-1:0]               cfg_mu_on,
  output logic                       pi_valid,
  input  logic                       pi_ready,
  output logic [N_MODELS*W-1:0]      pi_row,
  output logic [$clog2(N_MODELS)-1:0] pi_row_idx,
  output logic                       pi_last,
  output logic [N_MODELS-1:0]        model_active,
  output logic [$clog2(N_MODELS)-1:0] dominant
);

  localparam int IW        = $clog2(N_MODELS);
  localparam int FRAC_BITS = 16;
  localparam int CMAX      = (DEACT_CNT > REACT_CNT) ? DEACT_CNT : REACT_CNT;
  localparam int CW        = $clog2(CMAX + 1);
  localparam int RN        = 1 << (IW + 1);
  localparam logic [W-1:0] ONE = W'(1 << FRAC_BITS);

  typedef enum logic [1:0] {IDLE, ANALYZE, EMIT} state_t;

  state_t                 state_q;
  logic                   in_ready_q;
  logic [N_MODELS*W-1:0]  mu_q, nis_q;
  logic                   man_q, vs_q;
  logic [CW-1:0]          off_q [N_MODELS];
  logic [CW-1:0]          on_q  [N_MODELS];
  logic [CW-1:0]          off_d [N_MODELS];
  logic [CW-1:0]          on_d  [N_MODELS];
  logic [N_MODELS-1:0]    act_q, act_d;
  logic [IW-1:0]          dom_q, dom_d;
  logic [W-1:0]           psw_q, psw_d;
  logic [N_MODELS-1:0]    hi_q, hi_d;
  logic                   pi_valid_q, pi_last_q;
  logic [N_MODELS*W-1:0]  pi_row_q;
  logic [IW-1:0]          pi_idx_q;

  logic signed [W-1:0]    max_v;
  logic [W-1:0]           p_stay;
  logic [IW:0]            n_act;
  logic [IW:0]            km1;
  logic signed [2*W-1:0]  prod;
  logic [W-1:0]           recip_tab [RN];

  // recip_tab[k] = 1/k in Q16.16; index 0 is never selected since at least 2 models stay active
  for (genvar g = 0; g < RN; g++) begin : g_recip
    assign recip_tab[g] = (g == 0) ? ONE : W'(65536 / g);
  end

  function automatic logic [N_MODELS*W-1:0] build_row(input logic [IW-1:0] i,
                                                      input logic [N_MODELS-1:0] act,
                                                      input logic [W-1:0] psw,
                                                      input logic [N_MODELS-1:0] hi);
    logic [N_MODELS*W-1:0] row;
    logic [W-1:0] sum, v;
    row = '0;
    sum = '0;
    for (int j = 0; j < N_MODELS; j++) begin
      if (IW'(j) != i) begin
        if (!act[j])    v = '0;
        else if (hi[j]) v = W'($signed(psw) >>> 1);
        else            v = psw;
        row[j*W +: W] = v;
        sum = sum + v;
      end
    end
    row[int'(i)*W +: W] = ONE - sum;
    return row;
  endfunction

  always_comb begin
    dom_d = '0;
    max_v = $signed(mu_q[W-1:0]);
    for (int m = 1; m < N_MODELS; m++) begin
      if ($signed(mu_q[m*W +: W]) > max_v) begin
        max_v = $signed(mu_q[m*W +: W]);
        dom_d = IW'(m);
      end
    end

    if (!vs_q)                                p_stay = cfg_p_base;
    else if (max_v >= $signed(cfg_conf_hi))   p_stay = (man_q && dom_d == '0) ? cfg_p_low : cfg_p_high;
    else if (max_v >= $signed(cfg_conf_med))  p_stay = cfg_p_med;
    else                                      p_stay = cfg_p_low;

    act_d = act_q;
    n_act = '0;
    for (int m = 0; m < N_MODELS; m++) begin
      off_d[m] = '0;
      on_d[m]  = '0;
      hi_d[m]  = vs_q && ($signed(nis_q[m*W +: W]) > $signed(cfg_nis_thr));
      if (vs_q) begin
        if ($signed(mu_q[m*W +: W]) < $signed(cfg_mu_off))
          off_d[m] = (off_q[m] >= CW'(DEACT_CNT)) ? off_q[m] : off_q[m] + 1'b1;
        else if ($signed(mu_q[m*W +: W]) >= $signed(cfg_mu_on))
          on_d[m] = (on_q[m] >= CW'(REACT_CNT)) ? on_q[m] : on_q[m] + 1'b1;
        if (man_q || on_d[m] >= CW'(REACT_CNT)) act_d[m] = 1'b1;
      end else begin
        act_d[m] = 1'b1;
      end
      n_act = n_act + {{IW{1'b0}}, act_d[m]};
    end

    // Deactivations are granted in index order so the active count never drops below two
    if (vs_q && !man_q) begin
      for (int m = 0; m < N_MODELS; m++) begin
        if (act_d[m] && off_d[m] >= CW'(DEACT_CNT) && IW'(m) != dom_d && n_act > (IW+1)'(2)) begin
          act_d[m] = 1'b0;
          n_act    = n_act - 1'b1;
        end
      end
    end

    km1   = n_act - 1'b1;
    prod  = $signed(ONE - p_stay) * $signed(recip_tab[km1]);
    psw_d = W'(prod >>> FRAC_BITS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      mu_q       <= '0;
      nis_q      <= '0;
      man_q      <= 1'b0;
      vs_q       <= 1'b0;
      act_q      <= '1;
      dom_q      <= '0;
      psw_q      <= '0;
      hi_q       <= '0;
      pi_valid_q <= 1'b0;
      pi_last_q  <= 1'b0;
      pi_row_q   <= '0;
      pi_idx_q   <= '0;
      for (int m = 0; m < N_MODELS; m++) begin
        off_q[m] <= '0;
        on_q[m]  <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            mu_q       <= mu;
            nis_q      <= nis;
            man_q      <= maneuver;
            vs_q       <= vs_enable;
            in_ready_q <= 1'b0;
            state_q    <= ANALYZE;
          end
        end
        ANALYZE: begin
          dom_q      <= dom_d;
          act_q      <= act_d;
          psw_q      <= psw_d;
          hi_q       <= hi_d;
          for (int m = 0; m < N_MODELS; m++) begin
            off_q[m] <= off_d[m];
            on_q[m]  <= on_d[m];
          end
          pi_row_q   <= build_row('0, act_d, psw_d, hi_d);
          pi_idx_q   <= '0;
          pi_last_q  <= 1'b0;
          pi_valid_q <= 1'b1;
          state_q    <= EMIT;
        end
        EMIT: begin
          if (pi_ready) begin
            if (pi_last_q) begin
              pi_valid_q <= 1'b0;
              pi_last_q  <= 1'b0;
              pi_row_q   <= '0;
              pi_idx_q   <= '0;
              in_ready_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              pi_idx_q  <= pi_idx_q + 1'b1;
              pi_row_q  <= build_row(pi_idx_q + 1'b1, act_q, psw_q, hi_q);
              pi_last_q <= (pi_idx_q + 1'b1) == IW'(N_MODELS - 1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign pi_valid     = pi_valid_q;
  assign pi_row       = pi_row_q;
  assign pi_row_idx   = pi_idx_q;
  assign pi_last      = pi_last_q;
  assign model_active = act_q;
  assign dominant     = dom_q;

endmodule
